ahb_lite_decoder_mux: RTL and testbench

//  Parametrised AHB-Lite interconnect front-end: address decoder for NUM_SLAVES regions plus

---
 rtl/ahb_lite_pkg.sv | 22 ++
 rtl/ahb_lite_decoder_mux_if.sv | 27 ++
 rtl/ahb_lite_default_slave.sv | 52 +++++
 rtl/ahb_lite_decoder_mux.sv | 74 +++++++
 tb/tb_ahb_lite_decoder_mux.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite transfer/response codes, default memory map, default-slave states.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] AES_BASE    = 32'h4000_0000;
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_lite_decoder_mux_if.sv
// rtl/ahb_lite_decoder_mux_if.sv - Bus-side signal bundle between master, interconnect and slaves.
interface ahb_lite_decoder_mux_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
);
  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic [NUM_SLAVES-1:0]            HSEL;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]            HREADYOUT_S;
  logic [NUM_SLAVES-1:0]            HRESP_S;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic                             HREADY;
  logic                             HRESP;

  // master: the bus master plus the slave population driving the interconnect
  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL, HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL, HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_default_slave.sv
// rtl/ahb_lite_default_slave.sv - Default slave answering unmapped active transfers with a two-cycle ERROR.
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       hreadyout,
  output logic       hresp
);

  ds_state_e state_q;
  logic      hreadyout_q;
  logic      hresp_q;
  logic      start;

  assign start = HREADY & sel & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // ERR2 is itself an address-phase cycle, so it may chain straight into another ERR1
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= DS_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state_q)
        DS_ERR1: begin
          state_q     <= DS_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          if (start) begin
            state_q     <= DS_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// rtl/ahb_lite_decoder_mux.sv - AHB-Lite address decoder, data-phase response mux and default slave.
module ahb_lite_decoder_mux
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {AES_BASE, MEM_BASE},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {REGION_MASK, REGION_MASK}
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_lite_decoder_mux_if.slave bus
);

  logic [NUM_SLAVES-1:0] hsel;
  logic                  def_sel;
  logic [NUM_SLAVES:0]   dsel_q;
  logic [NUM_SLAVES:0]   dsel_d;
  logic                  ds_hreadyout;
  logic                  ds_hresp;

  // Scan from the top down so the lowest matching index is the one left standing
  always_comb begin
    hsel    = '0;
    def_sel = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
        def_sel = 1'b0;
      end
    end
  end

  assign bus.HSEL = hsel;

  // Bit NUM_SLAVES of the data-phase select marks the default slave
  assign dsel_d = bus.HREADY ? {def_sel, hsel} : dsel_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb_lite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (def_sel),
    .HTRANS    (bus.HTRANS),
    .HREADY    (bus.HREADY),
    .hreadyout (ds_hreadyout),
    .hresp     (ds_hresp)
  );

  // With no slave bit set (post-reset or default slave) the default slave drives ready/resp
  always_comb begin
    bus.HRDATA = '0;
    bus.HREADY = ds_hreadyout;
    bus.HRESP  = ds_hresp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        bus.HRDATA = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        bus.HREADY = bus.HREADYOUT_S[i];
        bus.HRESP  = bus.HRESP_S[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// tb/tb_ahb_lite_decoder_mux.sv - Scoreboard bench for ahb_lite_decoder_mux.
module tb_ahb_lite_decoder_mux;
  import ahb_lite_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  htrans;
    int          tgt;
    int          waits;
    bit          err;
    logic [31:0] data;
  } xfer_t;

  localparam logic [31:0] MARK = 32'h5EED_0003;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_decoder_mux_if bus ();
  ahb_lite_decoder_mux_if #(.NUM_SLAVES(3)) bus3 ();

  ahb_lite_decoder_mux dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  ahb_lite_decoder_mux #(
    .NUM_SLAVES (3),
    .SLAVE_BASE ({32'h2000_0000, 32'h4000_0000, 32'h2000_0000}),
    .SLAVE_MASK ({3{32'hF000_0000}})
  ) dut3 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus3)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  xfer_t exp_q[$];
  xfer_t dir_q[$];
  xfer_t ap, dp;
  bit    dp_valid = 0;
  int    dp_cyc = 0;
  bit    mon_en = 0;
  int    mon_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: region 0x0xxx_xxxx is slave 0, 0x4xxx_xxxx slave 1, anything else is unmapped
  function automatic xfer_t mk(input logic [31:0] addr, input logic [1:0] tr, input int waits,
                               input bit err, input logic [31:0] data);
    xfer_t x;
    x.addr = addr;
    x.htrans = tr;
    case (addr[31:28])
      4'h0:    x.tgt = 0;
      4'h4:    x.tgt = 1;
      default: x.tgt = 2;
    endcase
    if (x.tgt == 2) begin
      x.waits = tr[1] ? 1 : 0;
      x.err   = tr[1];
      x.data  = 32'h0;
    end else if (!tr[1]) begin
      x.waits = 0;
      x.err   = 1'b0;
      x.data  = data;
    end else begin
      x.err   = err;
      x.waits = err ? 1 : waits;
      x.data  = data;
    end
    return x;
  endfunction

  function automatic xfer_t rnd();
    logic [3:0] nib;
    case ($urandom_range(0, 2))
      0:       nib = 4'h0;
      1:       nib = 4'h4;
      default: begin
        nib = 4'($urandom_range(1, 15));
        if (nib == 4'h4) nib = 4'h8;
      end
    endcase
    return mk({nib, 28'($urandom)}, 2'($urandom), $urandom_range(0, 2),
              ($urandom_range(0, 4) == 0), $urandom);
  endfunction

  function automatic xfer_t next_item();
    if (dir_q.size() > 0) return dir_q.pop_front();
    return rnd();
  endfunction

  task automatic drive();
    bus.HADDR  = ap.addr;
    bus.HTRANS = ap.htrans;
    for (int s = 0; s < 2; s++) begin
      bus.HRDATA_S[s*32 +: 32] = $urandom;
      bus.HREADYOUT_S[s]       = 1'($urandom);
      bus.HRESP_S[s]           = 1'($urandom);
    end
    if (dp_valid && dp.tgt < 2) begin
      bus.HRDATA_S[dp.tgt*32 +: 32] = dp.data;
      bus.HREADYOUT_S[dp.tgt]       = (dp_cyc == dp.waits);
      bus.HRESP_S[dp.tgt]           = dp.err && (dp_cyc + 1 >= dp.waits);
    end
  endtask

  task automatic step();
    bit rdy;
    rdy = !dp_valid || (dp_cyc == dp.waits);
    @(posedge HCLK);
    #1;
    if (rdy) begin
      dp = ap;
      dp_valid = 1;
      dp_cyc = 0;
      exp_q.push_back(ap);
      ap = next_item();
    end else begin
      dp_cyc++;
    end
    drive();
    #1;
    check("hsel", 32'(bus.HSEL), (ap.tgt < 2) ? (32'd1 << ap.tgt) : 32'd0);
  endtask

  // Monitor: retire the head transfer whenever the master sees HREADY high
  always @(negedge HCLK) begin : monitor
    xfer_t e;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q[0];
      if (bus.HREADY === 1'b0) begin
        check("wait_hresp", 32'(bus.HRESP), 32'(e.err && (mon_cyc + 1 >= e.waits)));
        check("wait_budget", 32'(mon_cyc < e.waits), 32'd1);
        if (mon_cyc >= e.waits) begin
          void'(exp_q.pop_front());
          mon_cyc = 0;
        end else begin
          mon_cyc++;
        end
      end else begin
        check("data_phase_len", 32'(mon_cyc), 32'(e.waits));
        check("hrdata", bus.HRDATA, e.data);
        check("hresp", 32'(bus.HRESP), 32'(e.err));
        void'(exp_q.pop_front());
        mon_cyc = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    HRESETn = 1'b0;
    bus.HADDR = 32'h0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HRDATA_S = {32'hDEAD_BEEF, 32'h1234_5678};
    bus.HREADYOUT_S = 2'b00;
    bus.HRESP_S = 2'b11;
    bus3.HADDR = 32'h0;
    bus3.HTRANS = HTRANS_IDLE;
    bus3.HRDATA_S = '0;
    bus3.HREADYOUT_S = '1;
    bus3.HRESP_S = '0;
    #2;
    check("reset_hready", 32'(bus.HREADY), 32'd1);
    check("reset_hresp", 32'(bus.HRESP), 32'd0);
    check("reset_hrdata", bus.HRDATA, 32'h0);

    bus3.HADDR = 32'h2000_0000; #1;
    check("overlap_hsel", 32'(bus3.HSEL), 32'h1);
    bus3.HADDR = 32'h2ABC_0010; #1;
    check("overlap_hsel2", 32'(bus3.HSEL), 32'h1);
    bus3.HADDR = 32'h4000_0000; #1;
    check("overlap_hsel_s1", 32'(bus3.HSEL), 32'h2);
    bus3.HADDR = 32'h9000_0000; #1;
    check("overlap_hsel_def", 32'(bus3.HSEL), 32'h0);

    dir_q.push_back(mk(32'h4000_0000, HTRANS_NONSEQ, 2, 0, 32'hCAFE_BABE));
    dir_q.push_back(mk(32'h8000_0000, HTRANS_NONSEQ, 0, 0, 32'h0));
    dir_q.push_back(mk(32'h8000_0000, HTRANS_IDLE, 0, 0, 32'h0));
    dir_q.push_back(mk(32'h0000_0010, HTRANS_NONSEQ, 1, 0, 32'h1111_0000));
    dir_q.push_back(mk(32'h8000_0000, HTRANS_NONSEQ, 0, 0, 32'h0));
    dir_q.push_back(mk(32'h4000_0004, HTRANS_NONSEQ, 0, 0, 32'h2222_0000));

    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    ap = next_item();
    dp_valid = 0;
    drive();
    mon_en = 1;

    for (int c = 0; c < 400; c++) step();

    // Reset in the middle of a slave-1 wait state
    dir_q.push_back(mk(32'h4000_0000, HTRANS_NONSEQ, 3, 0, MARK));
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      step();
      if (dp_valid && dp.data == MARK && dp_cyc == 1) hit = 1;
    end
    check("reset_setup_reached", 32'(hit), 32'd1);
    if (hit) begin
      check("pre_reset_wait", 32'(bus.HREADY), 32'd0);
      mon_en = 0;
      HRESETn = 1'b0;
      #1;
      check("async_reset_hready", 32'(bus.HREADY), 32'd1);
      check("async_reset_hresp", 32'(bus.HRESP), 32'd0);
      check("async_reset_hrdata", bus.HRDATA, 32'h0);
      bus.HADDR = 32'h4000_0004;
      #1;
      check("reset_hsel_comb", 32'(bus.HSEL), 32'h2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
